// File: rtl/frame_scroll_scheduler.sv
// Frame scroll scheduler: once per frame it decides whether the world must scroll, sweeps
// every platform slot through the update handshake, then shifts the doodle and scores the scroll.
module frame_scroll_scheduler #(
  parameter int SCROLL_LINE = 200,
  parameter int MAX_STEP    = 8,
  parameter int N_PLAT      = 93
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [9:0] doodle_y,
  input  logic       doodle_falling,
  output logic       upd_req,
  output logic [6:0] upd_idx,
  output logic [3:0] upd_dy,
  input  logic       upd_ack,
  output logic       doodle_shift,
  output logic       busy,
  output logic [15:0] score,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [9:0] SCROLL_LINE_C = 10'(SCROLL_LINE);
  localparam logic [9:0] MAX_STEP_C    = 10'(MAX_STEP);
  localparam logic [6:0] LAST_IDX_C    = 7'(N_PLAT - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic [9:0]  y_r;
  logic        trigger_s;
  logic        handshake_s;
  logic        last_s;
  logic        upd_req_s;
  logic        doodle_shift_s;
  logic        busy_s;

  // Scroll amount: distance above the scroll line, capped at the per-frame maximum.
  function automatic logic [3:0] calc_dy(input logic [9:0] y);
    logic [9:0] gap;
    gap = SCROLL_LINE_C - y;
    if (gap > MAX_STEP_C) begin
      calc_dy = 4'(MAX_STEP_C);
    end else begin
      calc_dy = 4'(gap);
    end
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'd0, b};
    if (sum[16]) begin
      sat_add = 16'hFFFF;
    end else begin
      sat_add = sum[15:0];
    end
  endfunction

  assign trigger_s   = frame_start && !doodle_falling && (doodle_y < SCROLL_LINE_C);
  assign handshake_s = upd_req && upd_ack;
  assign last_s      = (upd_idx == LAST_IDX_C);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (trigger_s) begin
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: next_state_s = SWEEP;
      SWEEP: begin
        if (handshake_s && last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SWEEP;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the control outputs leave flops.
  always_comb begin
    upd_req_s      = 1'b0;
    doodle_shift_s = 1'b0;
    busy_s         = 1'b1;
    case (next_state_s)
      IDLE:    busy_s = 1'b0;
      CALC:    busy_s = 1'b1;
      SWEEP:   upd_req_s = 1'b1;
      DONE:    doodle_shift_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_req      <= 1'b0;
      doodle_shift <= 1'b0;
      busy         <= 1'b0;
    end else begin
      upd_req      <= upd_req_s;
      doodle_shift <= doodle_shift_s;
      busy         <= busy_s;
    end
  end

  // Datapath: sampled height, sweep index, scroll amount, score and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_r     <= 10'd0;
      upd_idx <= 7'd0;
      upd_dy  <= 4'd0;
      score   <= 16'd0;
      overrun <= 1'b0;
    end else begin
      if ((state_r == IDLE) && trigger_s) begin
        y_r <= doodle_y;
      end
      if (state_r == CALC) begin
        upd_dy  <= calc_dy(y_r);
        upd_idx <= 7'd0;
      end else if ((state_r == SWEEP) && handshake_s && !last_s) begin
        upd_idx <= upd_idx + 7'd1;
      end
      if (state_r == DONE) begin
        score <= sat_add(score, upd_dy);
      end
      if (frame_start && busy) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
